// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: command/state encodings and default timing shared by the bank scheduler
package sdram_sched_pkg;
    typedef enum logic [1:0] {NOP = 2'd0, PRE = 2'd1, WR = 2'd2, ACT = 2'd3} cmd_t;
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} bank_state_t;
    localparam int DEF_BA_WIDTH = 3;
    localparam int DEF_TWR = 4;
    localparam int DEF_TRCD = 3;
    localparam int DEF_TRP = 3;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/sdram_bank_timer.sv
// sdram_bank_timer: one bank's IDLE/ACTIVE state plus saturating tRP/tRCD/tWR down-counters
module sdram_bank_timer
    import sdram_sched_pkg::*;
#(
    parameter int TWR = DEF_TWR,
    parameter int TRCD = DEF_TRCD,
    parameter int TRP = DEF_TRP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue,
    input  logic [1:0] issue_cmd,
    output logic       is_open,
    output logic       act_ok,
    output logic       wr_ok,
    output logic       pre_ok
);
    localparam int TW = $clog2(max3(TWR, TRCD, TRP) + 2);
    bank_state_t state, state_nxt;
    logic [TW-1:0] t_rp, t_rcd, t_wr;
    cmd_t ic;
    assign ic = cmd_t'(issue_cmd);
    always_comb begin
        state_nxt = !issue ? state : (ic == ACT) ? ACTIVE : (ic == PRE) ? IDLE : state;
    end
    // Loaded at the handshake edge, so a counter reads zero exactly N cycles after the accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t_rp  <= '0;
            t_rcd <= '0;
            t_wr  <= '0;
        end else begin
            state <= state_nxt;
            t_rp  <= (issue && ic == PRE) ? TW'(TRP - 1)  : t_rp  - TW'(t_rp  != '0);
            t_rcd <= (issue && ic == ACT) ? TW'(TRCD - 1) : t_rcd - TW'(t_rcd != '0);
            t_wr  <= (issue && ic == WR)  ? TW'(TWR)      : t_wr  - TW'(t_wr  != '0);
        end
    end
    assign is_open = (state == ACTIVE);
    assign act_ok  = !is_open && (t_rp == '0);
    assign wr_ok   = is_open && (t_rcd == '0);
    assign pre_ok  = is_open && (t_wr == '0);
endmodule

// File: rtl/sdram_bank_scheduler.sv
// sdram_bank_scheduler: per-bank ACT/WR/PRE timing gate with a registered command bus
// Optional SDRAM_SCHED_FV_EN adds embedded properties and a free fv_bank input.
module sdram_bank_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int BA_WIDTH = DEF_BA_WIDTH,
    parameter int TWR = DEF_TWR,
    parameter int TRCD = DEF_TRCD,
    parameter int TRP = DEF_TRP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_cmd,
    input  logic [BA_WIDTH-1:0]    req_bank,
    output logic                   cmd_valid,
    output logic [1:0]             cmd,
    output logic [BA_WIDTH-1:0]    bank,
    output logic                   err,
    output logic [2**BA_WIDTH-1:0] open_mask
`ifdef SDRAM_SCHED_FV_EN
    ,
    input  logic [BA_WIDTH-1:0]    fv_bank
`endif
);
    localparam int NBANK = 2 ** BA_WIDTH;
    if (TWR < 1 || TRCD < 1 || TRP < 1) begin : g_bad_timing
        $error("sdram_bank_scheduler: TWR, TRCD and TRP must all be at least 1");
    end
    cmd_t rc;
    logic [NBANK-1:0] act_ok, wr_ok, pre_ok;
    logic legal, tmg_ok, fire, bad;
    assign rc = cmd_t'(req_cmd);
    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        sdram_bank_timer #(.TWR(TWR), .TRCD(TRCD), .TRP(TRP)) u_timer (
            .clk       (clk),
            .rst       (rst),
            .issue     (fire && (req_bank == BA_WIDTH'(i))),
            .issue_cmd (req_cmd),
            .is_open   (open_mask[i]),
            .act_ok    (act_ok[i]),
            .wr_ok     (wr_ok[i]),
            .pre_ok    (pre_ok[i])
        );
    end
    // Illegal requests and NOPs are always accepted; only legal ones wait on bank timing.
    always_comb begin
        legal     = (rc == ACT) ? !open_mask[req_bank] : (rc != NOP) && open_mask[req_bank];
        tmg_ok    = (rc == ACT) ? act_ok[req_bank] : (rc == WR) ? wr_ok[req_bank] : pre_ok[req_bank];
        req_ready = !legal || tmg_ok;
        fire      = req_valid && legal && tmg_ok;
        bad       = req_valid && (rc != NOP) && !legal;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd       <= NOP;
            bank      <= '0;
            err       <= 1'b0;
        end else begin
            cmd_valid <= fire;
            cmd       <= fire ? req_cmd : NOP;
            bank      <= fire ? req_bank : '0;
            err       <= bad;
        end
    end
`ifdef SDRAM_SCHED_FV_EN
    default clocking fv_cb @(posedge clk); endclocking
    default disable iff (rst);
    logic fv_wr, fv_act, fv_pre;
    assign fv_wr  = cmd_valid && (cmd == WR) && (bank == fv_bank);
    assign fv_act = cmd_valid && (cmd == ACT) && (bank == fv_bank);
    assign fv_pre = cmd_valid && (cmd == PRE) && (bank == fv_bank);
    asm_fv_bank: assume property ($stable(fv_bank));
    asm_hold: assume property (req_valid && !req_ready |=> req_valid && $stable(req_cmd) && $stable(req_bank));
    ast_twr: assert property (fv_wr |=> !fv_pre [*TWR]);
    if (TRCD > 1) begin : g_trcd
        ast_trcd: assert property (fv_act |=> !fv_wr [*TRCD-1]);
    end
    if (TRP > 1) begin : g_trp
        ast_trp: assert property (fv_pre |=> !fv_act [*TRP-1]);
    end
`endif
endmodule

// File: tb/tb_sdram_bank_scheduler.sv
// tb_sdram_bank_scheduler: directed stimulus with a command scoreboard and stall/err/open_mask checks
module tb_sdram_bank_scheduler;
    import sdram_sched_pkg::*;
    logic clk = 1'b0;
    logic rst, req_valid, req_ready, cmd_valid, err;
    logic [1:0] req_cmd, cmd;
    logic [2:0] req_bank, bank;
    logic [7:0] open_mask, exp_mask;
    logic [4:0] sbq[$];
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    sdram_bank_scheduler #(.BA_WIDTH(3), .TWR(4), .TRCD(3), .TRP(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_bank  (req_bank),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .bank      (bank),
        .err       (err),
        .open_mask (open_mask)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every issued command must match the oldest accepted legal request.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                chk("issue_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) chk("issue_cmd_bank", 32'({cmd, bank}), 32'(sbq.pop_front()));
            end else begin
                chk("idle_bus", 32'({cmd, bank}), 32'd0);
            end
        end
    end

    task automatic send(input string tag, input cmd_t c, input logic [2:0] b,
                        input int exp_stall, input logic exp_err);
        int st = 0;
        req_valid = 1'b1;
        req_cmd = c;
        req_bank = b;
        #1;
        while (!req_ready && st < 20) begin
            @(negedge clk);
            #1;
            st++;
        end
        chk({tag, "_stall"}, 32'(st), 32'(exp_stall));
        if (!exp_err && c != NOP) begin
            sbq.push_back({c, b});
            if (c == ACT) exp_mask[b] = 1'b1;
            else if (c == PRE) exp_mask[b] = 1'b0;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd = NOP;
        req_bank = '0;
        @(negedge clk);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_mask"}, 32'(open_mask), 32'(exp_mask));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_cmd = NOP;
        req_bank = '0;
        exp_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_bank", 32'({cmd, bank}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_open_mask", 32'(open_mask), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        // tRCD: WR right behind ACT waits two cycles
        send("act_b2", ACT, 3'd2, 0, 1'b0);
        send("wr_b2", WR, 3'd2, 2, 1'b0);
        // tWR: PRE right behind WR waits four cycles
        send("act_b5", ACT, 3'd5, 0, 1'b0);
        send("wr_b5", WR, 3'd5, 2, 1'b0);
        send("pre_b5", PRE, 3'd5, 4, 1'b0);
        // illegal requests are consumed immediately and flagged
        send("wr_idle_b1", WR, 3'd1, 0, 1'b1);
        send("pre_idle_b6", PRE, 3'd6, 0, 1'b1);
        send("act_open_b2", ACT, 3'd2, 0, 1'b1);
        send("nop", NOP, 3'd3, 0, 1'b0);
        // tRP on b0 while b7 activates unhindered
        send("act_b0", ACT, 3'd0, 0, 1'b0);
        send("pre_b0", PRE, 3'd0, 0, 1'b0);
        send("act_b7", ACT, 3'd7, 0, 1'b0);
        send("act_b0_again", ACT, 3'd0, 1, 1'b0);
        // back-to-back WR reloads tWR
        send("act_b3", ACT, 3'd3, 0, 1'b0);
        send("wr_b3_a", WR, 3'd3, 2, 1'b0);
        send("wr_b3_b", WR, 3'd3, 0, 1'b0);
        send("pre_b3", PRE, 3'd3, 4, 1'b0);
        // reset with b4 open and its tWR counter at 2, while a WR b2 is in flight
        send("act_b4", ACT, 3'd4, 0, 1'b0);
        send("wr_b4", WR, 3'd4, 2, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd = WR;
        req_bank = 3'd2;
        #1;
        chk("inflight_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        req_cmd = NOP;
        req_bank = '0;
        #1;
        chk("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("midrst_cmd_bank", 32'({cmd, bank}), 32'd0);
        chk("midrst_open_mask", 32'(open_mask), 32'd0);
        exp_mask = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        send("act_b4_post_rst", ACT, 3'd4, 0, 1'b0);
        send("act_b2_post_rst", ACT, 3'd2, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/sdram_bank_scheduler.md
Name: sdram_bank_scheduler

Overview:
- Per-bank SDRAM command scheduler between the memory front-end and the SDRAM command bus.
- Accepts one ACT/WR/PRE request per cycle over a valid/ready handshake.
- Tracks open/closed state and timing per bank, and stalls each request until its bank satisfies tRP, tRCD and tWR.
- Issues the command on a registered command bus; rejects protocol-illegal requests with an error pulse.

Parameters:
BA_WIDTH, 3, bank address width; NBANK = 2**BA_WIDTH banks
TWR, 4, write recovery: minimum cycles from WR to the next PRE, same bank
TRCD, 3, minimum cycles from ACT to the first WR, same bank
TRP, 3, minimum cycles from PRE to the next ACT, same bank

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted this cycle when req_valid&req_ready
req_cmd  in  2  0=NOP 1=PRE 2=WR 3=ACT
req_bank  in  BA_WIDTH  target bank
cmd_valid  out  1  command issued on cmd/bank this cycle
cmd  out  2  issued command, encoding as req_cmd; NOP when !cmd_valid
bank  out  BA_WIDTH  issued bank; 0 when !cmd_valid
err  out  1  one-cycle pulse: illegal request consumed and dropped
open_mask  out  NBANK  bit b=1 while bank b is ACTIVE

Behaviour:
- Reset (async assert, sync release): all banks IDLE with all timers 0; cmd_valid=0, cmd=NOP, bank=0, err=0, open_mask=0.
- Per-bank FSM has two states:
  - IDLE --ACT issued--> ACTIVE
  - ACTIVE --PRE issued--> IDLE
- A request is legal when:
  - ACT targets an IDLE bank;
  - WR or PRE targets an ACTIVE bank.
- NOP with req_valid: req_ready=1, consumed silently, no issue, no err.
- Illegal request: req_ready=1 the same cycle, err=1 next cycle, nothing issued, bank state unchanged.
- Legal request: req_ready=1 only when the bank timing condition holds; otherwise req_ready=0 and the request must be held stable by the requester.
- Timing rules, in issue cycles, same bank:
  - ACT no earlier than TRP cycles after PRE.
  - WR no earlier than TRCD cycles after ACT.
  - PRE no earlier than TWR+1 cycles after WR, i.e. cycles WR+1..WR+TWR never carry PRE to that bank.
- Timers per bank:
  - Down-counters loaded on issue; saturate at 0.
  - Width is $clog2(max(TWR,TRCD,TRP)+2).
  - A new WR reloads the tWR timer.
  - Back-to-back WRs to an open bank are allowed every cycle.
- req_ready is combinational from req_* and registered bank state.
- Latency: an accepted legal request appears on cmd/bank/cmd_valid exactly 1 cycle after the handshake.
- Banks are independent; a stall on one bank never delays timing on another.
- open_mask updates in the same cycle cmd_valid shows ACT/PRE.
- Reset mid-operation: immediate return to reset values; pending in-flight issue is dropped.
- Parameter TWR/TRCD/TRP=0 is illegal; an elaboration-time check fails.

Optional Feature:
- Macro SDRAM_SCHED_FV_EN.
- When defined, the block embeds concurrent assertions under default clocking @(posedge clk) and disable iff(rst), plus a $stable-constrained free bank input for bank-generic proofs:
  - WR to bank b is never followed by PRE to b for TWR cycles;
  - ACT to b is never followed by WR to b within TRCD-1 cycles;
  - PRE to b is never followed by ACT to b within TRP-1 cycles;
  - req_valid&&!req_ready implies the request is stable next cycle (assume).
- When undefined, no assertions, assumptions or extra inputs are present; RTL behaviour is identical.

Decomposition:
- Package sdram_sched_pkg holds:
  - cmd_t enum (NOP, PRE, WR, ACT with values 0..3);
  - bank_state_t enum (IDLE, ACTIVE);
  - default timing localparams.
- Sub-module sdram_bank_timer holds one bank's FSM plus three timers, with outputs is_open, act_ok, wr_ok, pre_ok.
- The top generates NBANK instances and muxes the per-bank ok signals by req_bank.

Test Plan:
- ACT b2 at t0, WR b2 requested at t0+1 → stalled until issue at t0+TRCD (3); cmd=2, bank=2.
- WR b5 issued at t, PRE b5 requested at t+1 → req_ready=0 through t+3; PRE issued at t+5 (TWR=4); never at t+1..t+4.
- WR to idle b1 → req_ready=1, err=1 next cycle, cmd_valid=0, open_mask unchanged.
- PRE b0 issued at t, ACT b0 requested immediately → issued at t+3; meanwhile ACT b7 is issued without stall.
- WR b3 at t and t+1 (back-to-back), then PRE → PRE earliest at t+6 (tWR timer reloaded).
- Assert rst while b4 is ACTIVE with the tWR timer at 2 → next cycle open_mask=0; ACT b4 is accepted immediately after reset release.
